// File: rtl/tx_fifo_feeder.sv
// Byte FIFO feeding the UART transmit controller.
// Bursts are buffered; bytes leave one frame at a time.
module tx_fifo_feeder #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Wr_En,
    input  logic [DW-1:0] Wr_Data,
    input  logic          Ovf_Clr,
    output logic          Full,
    output logic          Empty,
    output logic [AW:0]   Level,
    output logic          Overflow_Sig,
    input  logic          TX_Done_Sig,
    output logic          TX_En_Sig,
    output logic [DW-1:0] TX_Data,
    output logic          Busy,
    output logic          Sent_Pulse
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic          tx_en_q, tx_en_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          busy_q, busy_d;
    logic          sent_q, sent_d;

    logic push;
    logic drop;
    logic pop;

    // FIFO bookkeeping: pointers, level, flags, sticky overflow
    always_comb begin
        push     = Wr_En && !full_q;
        drop     = Wr_En && full_q;
        pop      = (state_q == IDLE) && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
        if (Ovf_Clr) begin
            ovf_d = 1'b0;
        end
        // a dropped byte outranks a clear on the same edge
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Frame sequencer: IDLE pops, SEND holds, GAP forces enable low
    always_comb begin
        state_d   = state_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        sent_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d = mem[rd_ptr_q];
                    tx_en_d   = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (TX_Done_Sig) begin
                    tx_en_d = 1'b0;
                    sent_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                tx_en_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                tx_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Storage array; contents are not reset, only pointers are
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= Wr_Data;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
        end
    end

    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Level        = level_q;
    assign Overflow_Sig = ovf_q;
    assign TX_En_Sig    = tx_en_q;
    assign TX_Data      = tx_data_q;
    assign Busy         = busy_q;
    assign Sent_Pulse   = sent_q;

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Bench for tx_fifo_feeder: reference model with
// a byte scoreboard plus directed latency checks.
module tb_tx_fifo_feeder;

    logic       CLK;
    logic       RST_N;
    logic       Wr_En;
    logic [7:0] Wr_Data;
    logic       Ovf_Clr;
    logic       Full;
    logic       Empty;
    logic [4:0] Level;
    logic       Overflow_Sig;
    logic       TX_Done_Sig;
    logic       TX_En_Sig;
    logic [7:0] TX_Data;
    logic       Busy;
    logic       Sent_Pulse;

    tx_fifo_feeder #(.AW(4), .DW(8)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .Wr_En        (Wr_En),
        .Wr_Data      (Wr_Data),
        .Ovf_Clr      (Ovf_Clr),
        .Full         (Full),
        .Empty        (Empty),
        .Level        (Level),
        .Overflow_Sig (Overflow_Sig),
        .TX_Done_Sig  (TX_Done_Sig),
        .TX_En_Sig    (TX_En_Sig),
        .TX_Data      (TX_Data),
        .Busy         (Busy),
        .Sent_Pulse   (Sent_Pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard / reference model
    logic [7:0] q [$];
    int         m_st;
    logic       m_en;
    logic       m_sent;
    logic       m_ovf;
    logic [7:0] m_data;
    logic       m_full;
    logic       m_pop;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q.delete();
            m_st   = 0;
            m_en   = 1'b0;
            m_sent = 1'b0;
            m_ovf  = 1'b0;
            m_data = 8'h00;
        end else begin
            m_full = (q.size() == 16);
            m_pop  = (m_st == 0) && (q.size() != 0);
            if (Ovf_Clr) m_ovf = 1'b0;
            if (Wr_En && m_full) m_ovf = 1'b1;
            m_sent = 1'b0;
            case (m_st)
                0: if (m_pop) begin
                    m_data = q.pop_front();
                    m_en   = 1'b1;
                    m_st   = 1;
                end
                1: if (TX_Done_Sig) begin
                    m_en   = 1'b0;
                    m_sent = 1'b1;
                    m_st   = 2;
                end
                default: m_st = 0;
            endcase
            if (Wr_En && !m_full) q.push_back(Wr_Data);
        end
    end

    // DUT observation and per-cycle model comparison
    bit         chk_on  = 0;
    logic       en_prev = 1'b0;
    int         n_start = 0;
    int         n_sent  = 0;
    int         lvl_max = 0;
    logic [7:0] got [$];

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("level", Level, q.size());
            chk("empty", Empty, q.size() == 0);
            chk("full", Full, q.size() == 16);
            chk("ovf", Overflow_Sig, m_ovf);
            chk("tx_en", TX_En_Sig, m_en);
            chk("tx_data", TX_Data, m_data);
            chk("busy", Busy, m_st != 0);
            chk("sent", Sent_Pulse, m_sent);
        end
        if (TX_En_Sig && !en_prev) begin
            n_start++;
            got.push_back(TX_Data);
        end
        en_prev = TX_En_Sig;
        if (Sent_Pulse) n_sent++;
        if (int'(Level) > lvl_max) lvl_max = int'(Level);
    end

    // transmit controller stand-in: done after frame_len cycles
    bit auto_done = 0;
    int frame_len = 6;
    int cnt       = 0;

    initial begin
        TX_Done_Sig = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (auto_done) begin
                TX_Done_Sig = 1'b0;
                if (TX_En_Sig) begin
                    if (cnt >= frame_len) begin
                        TX_Done_Sig = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        Wr_En   = 1'b1;
        Wr_Data = d;
        tick();
        Wr_En   = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        while (!(Empty && !Busy && !TX_En_Sig) && i < max) begin
            tick();
            i++;
        end
        chk("drain_timeout", i < max, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int s0;
    int g0;

    initial begin
        RST_N   = 1'b0;
        Wr_En   = 1'b0;
        Wr_Data = 8'h00;
        Ovf_Clr = 1'b0;
        tick(3);
        @(negedge CLK);
        chk("rst_empty", Empty, 1);
        chk("rst_level", Level, 0);
        chk("rst_full", Full, 0);
        chk("rst_en", TX_En_Sig, 0);
        chk("rst_data", TX_Data, 8'h00);
        chk("rst_busy", Busy, 0);
        chk("rst_ovf", Overflow_Sig, 0);
        chk("rst_sent", Sent_Pulse, 0);
        chk_on = 1;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick(2);

        // single byte with latency check
        auto_done = 1;
        frame_len = 6;
        s0 = n_sent;
        wr(8'hA5);
        @(negedge CLK);
        chk("sb_empty_n", Empty, 0);
        chk("sb_en_n", TX_En_Sig, 0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("sb_en_n1", TX_En_Sig, 1);
        chk("sb_data", TX_Data, 8'hA5);
        wait_idle(200);
        chk("sb_sent", n_sent - s0, 1);
        chk("sb_level", Level, 0);

        // burst of 16 while the first frame is in flight
        frame_len = 20;
        lvl_max   = 0;
        s0        = n_start;
        g0        = got.size();
        for (int i = 0; i < 16; i++) wr(8'(i));
        wait_idle(2000);
        chk("burst_lvlmax", lvl_max, 15);
        chk("burst_frames", n_start - s0, 16);
        for (int i = 0; i < 16; i++) begin
            if (g0 + i < got.size())
                chk("burst_order", got[g0 + i], i);
            else
                chk("burst_missing", g0 + i, got.size());
        end

        // overflow: no done pulses, 1 in flight + 17 writes
        auto_done   = 0;
        TX_Done_Sig = 1'b0;
        wr(8'h11);
        tick(2);
        for (int i = 0; i < 17; i++) begin
            wr(8'h20 + 8'(i));
            if (i == 15) begin
                @(negedge CLK);
                chk("ovf_full16", Full, 1);
                chk("ovf_pre", Overflow_Sig, 0);
            end
        end
        @(negedge CLK);
        chk("ovf_set", Overflow_Sig, 1);
        chk("ovf_level", Level, 16);
        tick(5);
        @(negedge CLK);
        chk("ovf_sticky", Overflow_Sig, 1);
        Ovf_Clr = 1'b1;
        tick();
        Ovf_Clr = 1'b0;
        @(negedge CLK);
        chk("ovf_clr", Overflow_Sig, 0);
        Ovf_Clr = 1'b1;
        wr(8'hEE);
        Ovf_Clr = 1'b0;
        @(negedge CLK);
        chk("ovf_prio", Overflow_Sig, 1);
        chk("ovf_prio_lvl", Level, 16);
        Ovf_Clr = 1'b1;
        tick();
        Ovf_Clr = 1'b0;

        // handshake gap around a single done pulse at edge D
        TX_Done_Sig = 1'b1;
        tick();
        TX_Done_Sig = 1'b0;
        @(negedge CLK);
        chk("gap_en_d", TX_En_Sig, 0);
        chk("gap_sent_d", Sent_Pulse, 1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("gap_en_d1", TX_En_Sig, 0);
        chk("gap_sent_d1", Sent_Pulse, 0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("gap_en_d2", TX_En_Sig, 1);
        chk("gap_data", TX_Data, 8'h20);
        chk("gap_level", Level, 15);

        // reset mid-frame with 5 bytes queued
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i));
        tick(2);
        @(negedge CLK);
        chk("mid_level", Level, 5);
        chk("mid_en", TX_En_Sig, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mr_en", TX_En_Sig, 0);
        chk("mr_level", Level, 0);
        chk("mr_empty", Empty, 1);
        chk("mr_busy", Busy, 0);
        tick(2);
        RST_N = 1'b1;
        s0 = n_start;
        tick(10);
        @(negedge CLK);
        chk("mr_quiet", n_start - s0, 0);
        chk("mr_en_after", TX_En_Sig, 0);

        auto_done = 1;
        frame_len = 4;
        wr(8'h5A);
        wait_idle(200);
        chk("mr_new_frames", n_start - s0, 1);
        chk("mr_new_data", got[got.size() - 1], 8'h5A);

        tick(2);
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_fifo_feeder.md
Name: tx_fifo_feeder

Overview:
Byte-buffering stage directly upstream of the UART transmit controller. Accepts bytes from the system side through a single-cycle write strobe and stores them in a FIFO. Hands bytes one at a time to the transmit controller using its enable/done handshake, holding TX_Data stable for the whole frame. Lets producers burst bytes without tracking the serial bit rate.

Parameters:
AW, 4, FIFO address width; depth = 2^AW = 16 entries
DW, 8, data width; fixed at 8 to match the transmit controller

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
Wr_En  input  1  one-cycle write strobe
Wr_Data  input  8  byte to enqueue
Ovf_Clr  input  1  clears Overflow_Sig
Full  output  1  FIFO holds 16 entries
Empty  output  1  FIFO holds 0 entries
Level  output  5  current entry count, 0..16
Overflow_Sig  output  1  sticky flag: a write was dropped
TX_Done_Sig  input  1  one-cycle done pulse from the transmit controller
TX_En_Sig  output  1  enable to the transmit controller, registered
TX_Data  output  8  byte to the transmit controller, registered, stable while TX_En_Sig=1
Busy  output  1  FSM not in IDLE
Sent_Pulse  output  1  one-cycle pulse per completed byte

Behaviour:
- Reset: RST_N is asynchronous and active-low; clock is CLK. Reset clears all state, including when applied mid-frame; the transmit controller shares RST_N.
  - Resets to 0: pointers, Level, Full, Overflow_Sig, TX_En_Sig, TX_Data (8'h00), Busy, Sent_Pulse.
  - Resets to 1: Empty.
  - FSM resets to IDLE. FIFO contents are discarded.
- FIFO storage: circular buffer with AW-bit read/write pointers that wrap 15->0. Level is tracked by a separate 5-bit counter.
  - Full = (Level==16). Empty = (Level==0). Both are registered and consistent with Level.
- Write: accepted when Wr_En=1 and Full=0. Wr_Data goes to mem[wr_ptr], wr_ptr increments, Level increments.
- Dropped write: Wr_En=1 while Full=1 drops the byte and sets Overflow_Sig on that edge. Full is judged on the current Level, even if a pop happens on the same edge.
- Overflow_Sig: sticky until Ovf_Clr=1. If Ovf_Clr and a dropped write happen on the same edge, set wins.
- Simultaneous accepted write and pop: Level is unchanged and both pointers advance.
- FSM states are IDLE, SEND and GAP.
  - IDLE: if Empty=0, pop mem[rd_ptr] into TX_Data, set TX_En_Sig=1, go to SEND. Otherwise stay.
  - SEND: hold TX_En_Sig=1 with TX_Data frozen. On TX_Done_Sig=1, set TX_En_Sig=0 and Sent_Pulse=1 on the same edge, then go to GAP.
  - GAP: one cycle with TX_En_Sig=0 so the controller sees enable low after its done cycle and does not restart on stale data. Sent_Pulse returns to 0. Go to IDLE.
- TX_Done_Sig is ignored outside SEND.
- Latency:
  - First write to an empty FIFO at edge N gives Empty=0 after N and TX_En_Sig=1 after N+1.
  - Done seen at edge D gives TX_En_Sig=0 after D. The next TX_En_Sig=1 comes after D+2 at the earliest.
- Busy = (state != IDLE), registered with the state.
- Data order is strict FIFO with no reordering or duplication. Each popped byte is presented exactly once.

Test Plan:
- Single byte: reset, write 8'hA5 at edge 10 -> Empty=0 after edge 10; TX_En_Sig=1 and TX_Data=8'hA5 after edge 11; with the real transmit controller attached, TX_Pin_Out shows start bit, 1,0,1,0,0,1,0,1 LSB-first, stop bit(s); Sent_Pulse fires once; Level returns to 0.
- Burst fill: write 8'h00..8'h0F on 16 consecutive edges while a frame is in SEND -> Level reaches 15 and pops continue at the frame rate; no loss; the serial output sequence equals 00..0F in order.
- Overflow: hold SEND with no done pulse, write 17 bytes -> Full=1 after the 16th write, the 17th is dropped, Overflow_Sig=1 and stays 1; Ovf_Clr pulse -> Overflow_Sig=0.
- Overflow priority: Wr_En=1 with Full=1 and Ovf_Clr=1 on the same edge -> Overflow_Sig=1 (set wins).
- Handshake gap: model TX_Done_Sig as a single-cycle pulse at edge D with 2 bytes queued -> TX_En_Sig low during D+1..D+2, high again after D+2; TX_Data never changes while TX_En_Sig=1.
- Reset mid-operation: assert RST_N=0 during SEND with 5 bytes queued -> immediately TX_En_Sig=0, Level=0, Empty=1, Busy=0; after release no byte is transmitted until a new write.
